// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline control slice.
//   mul_state_t : multiplier sequencer states
//   REG_X0      : architectural zero register index (never a hazard source)
//   MUL_LAT_DEF : default number of cycles a MUL-type instruction occupies EX
package ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam int unsigned MUL_LAT_DEF = 4;

endpackage

// File: rtl/mul_sequencer.sv
// Multi-cycle multiplier sequencer: FSM plus cycle counter.
// A MUL entering EX in IDLE starts the sequence; the pipe sees mul_busy for MUL_LAT-1 cycles,
// then one DONE cycle (stretched while mem_wait is high) in which mul_done is asserted.
// Ports:
//   clk, rst   : core clock, synchronous active-high reset
//   ex_is_mul  : EX instruction is a MUL-type op (only sampled in IDLE)
//   mem_wait   : data memory not ready; keeps DONE from retiring
//   mul_busy   : multiplier occupies EX (combinational, includes the trigger cycle)
//   mul_done   : multiplier result valid this cycle
module mul_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,  // legal range 2..15
  parameter int unsigned CNT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_is_mul,
  input  logic mem_wait,
  output logic mul_busy,
  output logic mul_done
);

  // The trigger cycle counts as busy cycle 1, so the counter starts at 2 and the last busy
  // cycle is the one where the counter reads MUL_LAT-1.
  localparam logic [CNT_W-1:0] FirstCnt = CNT_W'(2);
  localparam logic [CNT_W-1:0] LastCnt  = CNT_W'(MUL_LAT - 1);

  mul_state_t       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mul_busy = 1'b0;
    mul_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ex_is_mul) begin
          mul_busy = 1'b1;
          cnt_d    = FirstCnt;
          state_d  = (MUL_LAT == 2) ? DONE : BUSY;
        end
      end
      BUSY: begin
        mul_busy = 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // Same instruction still sits in EX: no retrigger, leave only once memory is ready.
        mul_done = 1'b1;
        if (!mem_wait) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      state_d  = IDLE;
      cnt_d    = '0;
      mul_busy = 1'b0;
      mul_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline control for the 5-stage core.
// Produces bubble/flush/hold controls for the IF/ID and E registers and the PC from load-use
// detection, EX-stage jump/branch resolution, the multiplier sequencer and memory stalls.
// Ports:
//   clk, rst                  : core clock, synchronous active-high reset (forces outputs to 0)
//   id_rs1_index/id_rs2_index : source indices of the ID instruction
//   id_use_rs1/id_use_rs2     : ID instruction actually reads that source
//   ex_rd_index, ex_is_load   : destination and load flag of the EX instruction
//   ex_is_mul                 : EX instruction is a MUL-type op
//   ex_jb                     : EX jump or taken branch
//   mem_wait                  : data memory not ready
//   e_stall                   : insert a bubble into the E register
//   jb_flush                  : flush IF/ID and E registers
//   e_hold                    : hold the E register
//   pc_hold, ifid_hold        : hold the PC / IF/ID register
//   mul_done                  : multiplier result valid this cycle
module pipe_hazard_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1_index,
  input  logic [4:0] id_rs2_index,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd_index,
  input  logic       ex_is_load,
  input  logic       ex_is_mul,
  input  logic       ex_jb,
  input  logic       mem_wait,
  output logic       e_stall,
  output logic       jb_flush,
  output logic       e_hold,
  output logic       pc_hold,
  output logic       ifid_hold,
  output logic       mul_done
);

  logic mul_busy;
  logic seq_done;
  logic hazard;

  mul_sequencer #(
    .MUL_LAT(MUL_LAT),
    .CNT_W  (CNT_W)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .ex_is_mul(ex_is_mul),
    .mem_wait (mem_wait),
    .mul_busy (mul_busy),
    .mul_done (seq_done)
  );

  always_comb begin
    hazard = ex_is_load && (ex_rd_index != REG_X0) &&
             ((id_use_rs1 && (id_rs1_index == ex_rd_index)) ||
              (id_use_rs2 && (id_rs2_index == ex_rd_index)));

    // Hold beats flush beats bubble: a held jb stays in EX and is re-evaluated next cycle.
    e_hold    = mul_busy | mem_wait;
    jb_flush  = ex_jb & ~e_hold;
    e_stall   = hazard & ~e_hold & ~ex_jb;
    // On a flush the fetch unit redirects the PC, so no hold is requested.
    pc_hold   = e_hold | e_stall;
    ifid_hold = pc_hold;
    mul_done  = seq_done;

    if (rst) begin
      e_hold    = 1'b0;
      jb_flush  = 1'b0;
      e_stall   = 1'b0;
      pc_hold   = 1'b0;
      ifid_hold = 1'b0;
      mul_done  = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: expected output vectors are queued when a cycle's
// stimulus is applied and popped against the DUT outputs mid-cycle.
// Vector order: {e_stall, jb_flush, e_hold, pc_hold, ifid_hold, mul_done}.
module tb_pipe_hazard_ctrl;
  import ctrl_pkg::*;

  localparam int unsigned MulLat = 4;

  typedef struct {
    string      tag;
    logic [5:0] exp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1_index, id_rs2_index, ex_rd_index;
  logic       id_use_rs1, id_use_rs2, ex_is_load, ex_is_mul, ex_jb, mem_wait;
  logic       e_stall, jb_flush, e_hold, pc_hold, ifid_hold, mul_done;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  // Reference multiplier model: busy cycles still to come after the current one, and DONE flag.
  int   busy_left = 0;
  bit   in_done   = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MUL_LAT(MulLat),
    .CNT_W  (4)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1_index(id_rs1_index),
    .id_rs2_index(id_rs2_index),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd_index (ex_rd_index),
    .ex_is_load  (ex_is_load),
    .ex_is_mul   (ex_is_mul),
    .ex_jb       (ex_jb),
    .mem_wait    (mem_wait),
    .e_stall     (e_stall),
    .jb_flush    (jb_flush),
    .e_hold      (e_hold),
    .pc_hold     (pc_hold),
    .ifid_hold   (ifid_hold),
    .mul_done    (mul_done)
  );

  task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (stall,flush,ehold,pchold,ifidhold,done)",
               tag, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, queue the expectation, compare mid-cycle, advance the model.
  task automatic step(input string tag, input logic r, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic u1, input logic u2,
                      input logic [4:0] rd, input logic ld, input logic mul,
                      input logic jb, input logic mw);
    logic busy, hz, eh, fl, st, ph, dn;
    exp_t e;
    rst = r; id_rs1_index = rs1; id_rs2_index = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd_index = rd; ex_is_load = ld; ex_is_mul = mul; ex_jb = jb; mem_wait = mw;

    busy = (busy_left > 0) || (!in_done && busy_left == 0 && mul);
    dn   = in_done;
    hz   = ld && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    eh   = busy | mw;
    fl   = jb & ~eh;
    st   = hz & ~eh & ~jb;
    ph   = eh | st;
    e.tag = tag;
    e.exp = r ? 6'b0 : {st, fl, eh, ph, ph, dn};
    sb.push_back(e);

    #4;
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 6'h3f, 6'h00);
    end else begin
      e = sb.pop_front();
      check_eq(e.tag, {e_stall, jb_flush, e_hold, pc_hold, ifid_hold, mul_done}, e.exp);
    end

    if (r) begin
      busy_left = 0;
      in_done   = 1'b0;
    end else if (in_done) begin
      in_done = mw;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) in_done = 1'b1;
    end else if (mul) begin
      busy_left = MulLat - 2;
      if (busy_left == 0) in_done = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
  endtask

  task automatic mul_cyc(input string tag, input logic mul, input logic mw);
    step(tag, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, mul, 0, mw);
  endtask

  initial begin
    rst = 1'b1; id_rs1_index = '0; id_rs2_index = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd_index = '0; ex_is_load = 0; ex_is_mul = 0; ex_jb = 0; mem_wait = 0;
    @(posedge clk);
    #1;

    // Reset forces every output low even with active inputs.
    step("rst_a", 1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 1, 1);
    step("rst_b", 1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 1, 1);
    check_eq("rst_state", 6'(u_dut.u_seq.state_q), 6'(IDLE));
    idle("idle0");

    // Load-use hazards.
    step("lu_rs1", 0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0);
    idle("lu_after");
    step("lu_x0", 0, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0);
    step("lu_rs2", 0, 5'd1, 5'd9, 1, 1, 5'd9, 1, 0, 0, 0);
    step("lu_nouse", 0, 5'd9, 5'd9, 0, 0, 5'd9, 1, 0, 0, 0);
    step("lu_noload", 0, 5'd7, 5'd0, 1, 0, 5'd7, 0, 0, 0, 0);

    // Back-to-back MULs: busy,busy,busy,done twice with no gap.
    for (int i = 0; i < 8; i++) mul_cyc($sformatf("mul_b2b_%0d", i), 1, 0);
    mul_cyc("mul_b2b_end", 0, 0);

    // Flush wins over a simultaneous load-use bubble.
    step("jb_hz", 0, 5'd3, 5'd0, 1, 0, 5'd3, 1, 0, 1, 0);

    // Jump deferred by mem_wait, then released.
    for (int i = 0; i < 3; i++) step($sformatf("jb_wait_%0d", i), 0, 5'd0, 5'd0, 0, 0,
                                     5'd0, 0, 0, 1, 1);
    step("jb_release", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    idle("idle1");

    // mem_wait arriving in DONE stretches mul_done; mul input ignored meanwhile.
    mul_cyc("md_trig", 1, 0);
    mul_cyc("md_busy2", 0, 0);
    mul_cyc("md_busy3", 0, 0);
    mul_cyc("md_done_w0", 1, 1);
    mul_cyc("md_done_w1", 1, 1);
    mul_cyc("md_done", 0, 0);
    idle("md_idle");

    // Reset in BUSY cycle 2 aborts the multiply; a fresh MUL gets the full stall.
    mul_cyc("ra_trig", 1, 0);
    step("ra_rst", 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0);
    idle("ra_after");
    check_eq("ra_state", 6'(u_dut.u_seq.state_q), 6'(IDLE));
    mul_cyc("ra_new1", 1, 0);
    mul_cyc("ra_new2", 0, 0);
    mul_cyc("ra_new3", 0, 0);
    mul_cyc("ra_new4", 0, 0);
    idle("ra_idle");

    // Random mix against the reference model.
    for (int i = 0; i < 80; i++) begin
      step($sformatf("rnd_%0d", i), ($urandom_range(0, 29) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
